// File: rtl/rand_sum_pipeline.sv
// Traffic generator chain: two LFSR beat sources joined by an adder, drained by a
// sink with optional random backpressure that reports every beat and per-packet stats.
module rand_sum_pipeline #(
   parameter int          LEN     = 8,
   parameter int          PKT_LEN = 8,
   parameter logic [15:0] SEED0   = 16'h0001,
   parameter logic [15:0] SEED1   = 16'h0001,
   parameter logic [15:0] SEED2   = 16'hACE1,
   parameter bit          BUBBLES = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   output logic           out_valid,
   output logic           out_last,
   output logic [LEN-1:0] out_data,
   output logic [15:0]    pkt_count,
   output logic [LEN-1:0] pkt_sum,
   output logic           err
);

   localparam int             CW       = $clog2(PKT_LEN + 1);
   localparam logic [CW-1:0]  LAST_IDX = CW'(PKT_LEN - 1);

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   logic [15:0]    src_lfsr     [2];
   logic           src_valid    [2];
   logic           src_last     [2];
   logic           src_ready    [2];
   logic           src_hs       [2];
   logic [LEN-1:0] src_data     [2];
   logic [CW-1:0]  src_cnt      [2];
   logic [CW-1:0]  src_cnt_next [2];

   logic           sum_valid;
   logic           sum_last;
   logic [LEN-1:0] sum_data;
   logic           can_accept;
   logic           join_fire;
   logic           err_join;

   logic [15:0]    snk_lfsr;
   logic           snk_ready;
   logic           snk_hs;
   logic [CW-1:0]  snk_cnt;
   logic [LEN-1:0] acc;
   logic           err_sink;

   // Each source is offered ready only when its partner is valid, so they always pair up.
   always_comb begin
      can_accept   = !sum_valid || snk_ready;
      join_fire    = src_valid[0] && src_valid[1] && can_accept;
      src_ready[0] = can_accept && src_valid[1];
      src_ready[1] = can_accept && src_valid[0];
      snk_hs       = sum_valid && snk_ready;
      for (int i = 0; i < 2; i++) begin
         src_hs[i] = src_valid[i] && src_ready[i];
         if (src_hs[i]) begin
            src_cnt_next[i] = src_last[i] ? '0 : src_cnt[i] + 1'b1;
         end else begin
            src_cnt_next[i] = src_cnt[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            src_lfsr[i]  <= (i == 0) ? SEED0 : SEED1;
            src_valid[i] <= 1'b0;
            src_last[i]  <= 1'b0;
            src_data[i]  <= '0;
            src_cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!src_valid[i] || src_hs[i]) begin
               src_lfsr[i]  <= lfsr_step(src_lfsr[i]);
               src_data[i]  <= src_lfsr[i][LEN-1:0];
               src_valid[i] <= BUBBLES ? (src_lfsr[i][1:0] != 2'b00) : 1'b1;
               src_last[i]  <= (src_cnt_next[i] == LAST_IDX);
            end
            src_cnt[i] <= src_cnt_next[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_valid <= 1'b0;
         sum_last  <= 1'b0;
         sum_data  <= '0;
         err_join  <= 1'b0;
      end else if (join_fire) begin
         sum_valid <= 1'b1;
         sum_last  <= src_last[0];
         sum_data  <= src_data[0] + src_data[1];
         if (src_last[0] != src_last[1]) begin
            err_join <= 1'b1;
         end
      end else if (snk_hs) begin
         sum_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snk_lfsr  <= SEED2;
         snk_ready <= 1'b0;
         snk_cnt   <= '0;
         acc       <= '0;
         err_sink  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         pkt_count <= '0;
         pkt_sum   <= '0;
      end else begin
         snk_lfsr  <= lfsr_step(snk_lfsr);
         snk_ready <= BUBBLES ? snk_lfsr[0] : 1'b1;
         out_valid <= snk_hs;
         if (snk_hs) begin
            out_data <= sum_data;
            out_last <= sum_last;
            if (sum_last) begin
               pkt_sum   <= acc + sum_data;
               pkt_count <= pkt_count + 16'd1;
               snk_cnt   <= '0;
               acc       <= '0;
               if (snk_cnt != LAST_IDX) begin
                  err_sink <= 1'b1;
               end
            end else begin
               snk_cnt <= snk_cnt + 1'b1;
               acc     <= acc + sum_data;
               // A non-last beat in the final slot means the packet overran.
               if (snk_cnt == LAST_IDX) begin
                  err_sink <= 1'b1;
               end
            end
         end
      end
   end

   assign err = err_join | err_sink;

endmodule

// File: tb/tb_rand_sum_pipeline.sv
// Scoreboard bench: three instances (two unstalled directed cases, one with bubbles
// checked against an independent LFSR model plus link-stability checks).
module tb_rand_sum_pipeline;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a, rst_b, rst_c;
   logic       out_valid_a, out_last_a, err_a;
   logic [7:0] out_data_a, pkt_sum_a;
   logic [15:0] pkt_count_a;
   logic       out_valid_b, out_last_b, err_b;
   logic [7:0] out_data_b, pkt_sum_b;
   logic [15:0] pkt_count_b;
   logic       out_valid_c, out_last_c, err_c;
   logic [7:0] out_data_c, pkt_sum_c;
   logic [15:0] pkt_count_c;

   rand_sum_pipeline #(.LEN(8), .PKT_LEN(8), .SEED0(16'h0001), .SEED1(16'h0001),
                       .SEED2(16'hACE1), .BUBBLES(1'b0)) dut_a (
      .clk(clk), .rst(rst_a), .out_valid(out_valid_a), .out_last(out_last_a),
      .out_data(out_data_a), .pkt_count(pkt_count_a), .pkt_sum(pkt_sum_a), .err(err_a));

   rand_sum_pipeline #(.LEN(8), .PKT_LEN(8), .SEED0(16'h00FF), .SEED1(16'h0001),
                       .SEED2(16'hACE1), .BUBBLES(1'b0)) dut_b (
      .clk(clk), .rst(rst_b), .out_valid(out_valid_b), .out_last(out_last_b),
      .out_data(out_data_b), .pkt_count(pkt_count_b), .pkt_sum(pkt_sum_b), .err(err_b));

   rand_sum_pipeline #(.LEN(8), .PKT_LEN(8), .SEED0(16'h0001), .SEED1(16'hBEEF),
                       .SEED2(16'hACE1), .BUBBLES(1'b1)) dut_c (
      .clk(clk), .rst(rst_c), .out_valid(out_valid_c), .out_last(out_last_c),
      .out_data(out_data_c), .pkt_count(pkt_count_c), .pkt_sum(pkt_sum_c), .err(err_c));

   int n_vec = 0;
   int n_err = 0;
   logic [8:0] exp_a[$];
   logic [8:0] exp_b[$];
   logic [8:0] exp_c[$];
   logic [7:0] seq_a [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
   logic c_run = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic report_timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out waiting for output beats", name);
   endtask

   function automatic logic [15:0] model_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   task automatic push_a(input int n);
      for (int i = 0; i < n; i++) exp_a.push_back({(i == 7), seq_a[i]});
   endtask

   // Monitors pop one expectation per presented beat.
   always @(negedge clk) begin : mon_a
      logic [8:0] e;
      if (out_valid_a) begin
         if (exp_a.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL a_unexpected_beat: got data %0h with no expectation", out_data_a);
         end else begin
            e = exp_a.pop_front();
            check("a_data", 32'(out_data_a), 32'(e[7:0]));
            check("a_last", 32'(out_last_a), 32'(e[8]));
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [8:0] e;
      if (out_valid_b) begin
         if (exp_b.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL b_unexpected_beat: got data %0h with no expectation", out_data_b);
         end else begin
            e = exp_b.pop_front();
            check("b_data", 32'(out_data_b), 32'(e[7:0]));
         end
      end
   end

   always @(negedge clk) begin : mon_c
      logic [8:0] e;
      if (out_valid_c) begin
         if (exp_c.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL c_unexpected_beat: got data %0h with no expectation", out_data_c);
         end else begin
            e = exp_c.pop_front();
            check("c_data", 32'(out_data_c), 32'(e[7:0]));
            check("c_last", 32'(out_last_c), 32'(e[8]));
         end
      end
   end

   // Link stability and pairing checks on the stalled instance.
   logic [8:0] p_src [2];
   logic       p_sv  [2];
   logic       p_sr  [2];
   logic [8:0] p_sum;
   logic       p_sumv, p_snkr;
   logic       c_prev_ok = 1'b0;

   always @(negedge clk) begin : link_chk
      if (c_run) begin
         for (int i = 0; i < 2; i++) begin
            if (c_prev_ok && p_sv[i] && !p_sr[i])
               check("c_src_hold", 32'({dut_c.src_last[i], dut_c.src_data[i]}), 32'(p_src[i]));
            if (dut_c.src_valid[i] && dut_c.src_ready[i])
               check("c_join_pair", 32'(dut_c.src_valid[0] && dut_c.src_valid[1]), 32'd1);
            p_src[i] = {dut_c.src_last[i], dut_c.src_data[i]};
            p_sv[i]  = dut_c.src_valid[i];
            p_sr[i]  = dut_c.src_ready[i];
         end
         if (c_prev_ok && p_sumv && !p_snkr)
            check("c_sum_hold", 32'({dut_c.sum_last, dut_c.sum_data}), 32'(p_sum));
         p_sum     = {dut_c.sum_last, dut_c.sum_data};
         p_sumv    = dut_c.sum_valid;
         p_snkr    = dut_c.snk_ready;
         c_prev_ok = 1'b1;
      end
   end

   task automatic check_zero_a(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid_a), 32'd0);
      check({tag, "_out_last"},  32'(out_last_a),  32'd0);
      check({tag, "_out_data"},  32'(out_data_a),  32'd0);
      check({tag, "_pkt_count"}, 32'(pkt_count_a), 32'd0);
      check({tag, "_pkt_sum"},   32'(pkt_sum_a),   32'd0);
      check({tag, "_err"},       32'(err_a),       32'd0);
   endtask

   task automatic test_a();
      int beats;
      int cyc;
      push_a(8);
      rst_a = 1'b0;
      @(negedge clk); check("a_lat_k1", 32'(out_valid_a), 32'd0);
      @(negedge clk); check("a_lat_k2", 32'(out_valid_a), 32'd0);
      @(negedge clk); check("a_lat_k3", 32'(out_valid_a), 32'd1);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         check("a_throughput", 32'(out_valid_a), 32'd1);
      end
      check("a_pkt_count", 32'(pkt_count_a), 32'd1);
      check("a_pkt_sum",   32'(pkt_sum_a),   32'h0FE);
      check("a_err",       32'(err_a),       32'd0);
      rst_a = 1'b1;
      repeat (3) @(negedge clk);

      // Mid-packet reset pulse after three beats.
      push_a(3);
      rst_a = 1'b0;
      beats = 0;
      cyc   = 0;
      while (beats < 3 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (out_valid_a) beats++;
      end
      if (beats < 3) report_timeout("a_pre_reset_beats");
      rst_a = 1'b1;
      @(negedge clk);
      check_zero_a("a_rst_pulse");
      exp_a.delete();
      push_a(8);
      rst_a = 1'b0;
      beats = 0;
      cyc   = 0;
      while (beats < 8 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (out_valid_a) beats++;
      end
      if (beats < 8) report_timeout("a_restart_beats");
      check("a_restart_pkt_count", 32'(pkt_count_a), 32'd1);
      check("a_restart_pkt_sum",   32'(pkt_sum_a),   32'h0FE);
      check("a_restart_err",       32'(err_a),       32'd0);
      rst_a = 1'b1;
   endtask

   task automatic test_b();
      int beats;
      int cyc;
      exp_b.push_back(9'h000);
      exp_b.push_back(9'h000);
      rst_b = 1'b0;
      beats = 0;
      cyc   = 0;
      while (beats < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (out_valid_b) beats++;
      end
      if (beats < 2) report_timeout("b_beats");
      rst_b = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_c();
      logic [15:0] l0, l1;
      logic [7:0]  s0[$];
      logic [7:0]  s1[$];
      logic [7:0]  sum;
      int beats;
      l0 = 16'h0001;
      l1 = 16'hBEEF;
      while (s0.size() < 3000) begin
         if (l0[1:0] != 2'b00) s0.push_back(l0[7:0]);
         l0 = model_step(l0);
      end
      while (s1.size() < 3000) begin
         if (l1[1:0] != 2'b00) s1.push_back(l1[7:0]);
         l1 = model_step(l1);
      end
      for (int j = 0; j < 3000; j++) begin
         sum = s0[j] + s1[j];
         exp_c.push_back({(j % 8 == 7), sum});
      end
      rst_c = 1'b0;
      c_run = 1'b1;
      beats = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (out_valid_c) beats++;
      end
      check("c_progress",  32'(beats > 100), 32'd1);
      check("c_pkt_count", 32'(pkt_count_c), 32'(beats / 8));
      check("c_err",       32'(err_c),       32'd0);
      c_run = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      repeat (3) @(negedge clk);
      check_zero_a("a_reset");
      check("c_reset_out_valid", 32'(out_valid_c), 32'd0);
      check("c_reset_pkt_count", 32'(pkt_count_c), 32'd0);
      fork
         test_a();
         test_b();
         test_c();
      join
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
